// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Widths, reset PC and the FSM state encoding live here so every file agrees.
package ifu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC   = 32'h8000_0000;
  localparam logic [XLEN-1:0] INST_BYTES = 32'd4;

  // Redirect targets are forced onto an instruction boundary.
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~32'd3;

  typedef enum logic [1:0] {
    StReq  = 2'd0,
    StWait = 2'd1,
    StHold = 2'd2,
    StDrop = 2'd3
  } ifu_state_e;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/ifu_if.sv
// Bundle of the fetch unit's memory, decode and redirect channels.
// master is the fetch unit's view; slave is the memory / IDU / EXU side.
interface ifu_if;
  import ifu_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            imem_rsp_err;

  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_fault;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output inst_valid, inst, inst_pc, inst_fault,
    input  inst_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  inst_valid, inst, inst_pc, inst_fault,
    output inst_ready,
    output redirect_valid, redirect_pc
  );

endinterface

// File: rtl/ifu_inst_buf.sv
// One-entry valid/ready output register toward decode, with a flush input.
// Flush wins over load and consume; the payload is only meaningful while valid.
module ifu_inst_buf
  import ifu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [ILEN-1:0] load_inst_i,
  input  logic [XLEN-1:0] load_pc_i,
  input  logic            load_fault_i,
  input  logic            flush_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [ILEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic            fault_o
);

  logic            valid_q, valid_d;
  logic [ILEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;

  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      inst_d  = load_inst_i;
      pc_d    = load_pc_i;
      fault_d = load_fault_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
  assign fault_o = fault_q;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, keeps one imem read in flight and hands
// each returned word to decode; EXU redirects flush whatever is outstanding.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] ResetPc = RESET_PC
) (
  input logic   clk,
  input logic   rst,
  ifu_if.master bus
);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;

  logic req_valid;
  logic req_fire;
  logic buf_load;
  logic buf_flush;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StReq;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect takes priority everywhere
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReq: begin
        if (bus.redirect_valid) begin
          state_d = StReq;
        end else if (req_fire) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.redirect_valid) begin
          state_d = bus.imem_rsp_valid ? StReq : StDrop;
        end else if (bus.imem_rsp_valid) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (bus.redirect_valid || bus.inst_ready) begin
          state_d = StReq;
        end
      end
      StDrop: begin
        // A stale response still owes us a pulse; only its arrival frees the channel.
        if (bus.imem_rsp_valid) begin
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  // Output / control decode
  always_comb begin
    req_valid = rst && (state_q == StReq) && !bus.redirect_valid;
    req_fire  = req_valid && bus.imem_req_ready;
    buf_load  = (state_q == StWait) && bus.imem_rsp_valid && !bus.redirect_valid;
    buf_flush = bus.redirect_valid;
  end

  always_comb begin
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    if (req_fire) begin
      fetch_pc_d = pc_q;
    end
    if (bus.redirect_valid) begin
      pc_d = align_pc(bus.redirect_pc);
    end else if (buf_load) begin
      pc_d = fetch_pc_q + INST_BYTES;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= ResetPc;
      fetch_pc_q <= ResetPc;
    end else begin
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;

  ifu_inst_buf u_inst_buf (
    .clk          (clk),
    .rst          (rst),
    .load_i       (buf_load),
    .load_inst_i  (bus.imem_rsp_data),
    .load_pc_i    (fetch_pc_q),
    .load_fault_i (bus.imem_rsp_err),
    .flush_i      (buf_flush),
    .ready_i      (bus.inst_ready),
    .valid_o      (bus.inst_valid),
    .inst_o       (bus.inst),
    .pc_o         (bus.inst_pc),
    .fault_o      (bus.inst_fault)
  );

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the single-issue NPC core. Owns the architectural PC, issues one instruction-memory read at a time over a valid/ready request channel, and captures the returned word. Presents the word to the decode stage (IDU) through a one-entry valid/ready buffer together with its PC. Accepts PC redirects from the execute stage, which flush any fetch still in flight.

## Interface
Parameters:
- XLEN, 32, data/address width
- ILEN, 32, instruction width
- RESET_PC, 32'h8000_0000, first fetch address

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address
- imem_rsp_valid  in  1  response valid, one-cycle pulse, exactly one per accepted request
- imem_rsp_data  in  ILEN  fetched word
- imem_rsp_err  in  1  access fault for this response
- inst_valid  out  1  buffered instruction valid
- inst_ready  in  1  IDU consumes instruction
- inst  out  ILEN  instruction word
- inst_pc  out  XLEN  PC of inst
- inst_fault  out  1  fetch faulted; inst is don't-care
- redirect_valid  in  1  PC redirect from EXU
- redirect_pc  in  XLEN  redirect target

## Operation
- Registers: pc, fetch_pc, buffer (inst, inst_pc, inst_fault, inst_valid), state.
- States: S_REQ, S_WAIT, S_HOLD, S_DROP. At most one request outstanding.
- S_REQ: imem_req_valid = !redirect_valid; imem_req_addr = pc. On handshake: fetch_pc <= pc, go to S_WAIT.
- S_WAIT: on imem_rsp_valid, load the buffer with rsp_data, fetch_pc and rsp_err, set inst_valid, set pc <= fetch_pc + 4, go to S_HOLD.
- S_HOLD: inst_valid = 1, outputs stable. On inst_ready, clear inst_valid and go to S_REQ.
- S_DROP: a stale response is pending. On imem_rsp_valid, discard it and go to S_REQ.
- Redirect has priority in every state:
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - Buffer is invalidated. In S_HOLD with inst_ready in the same cycle, the handshake still counts, but pc takes the redirect.
  - Next state: S_REQ from S_REQ, S_HOLD, or S_WAIT/S_DROP when rsp_valid arrives in the same cycle (that response is discarded). Otherwise S_DROP from S_WAIT/S_DROP.
- imem_rsp_valid in S_REQ or S_HOLD is ignored. This is a protocol error; the bench flags it.
- pc + 4 wraps modulo 2^XLEN.

## Timing
- Reset (rst = 0 at a clock edge):
  - state = S_REQ, pc = RESET_PC.
  - inst_valid = 0, inst = 0, inst_pc = 0, inst_fault = 0.
  - imem_req_valid is forced to 0 while rst = 0.
- Reset mid-operation aborts everything. The memory shares the reset, so no response from before reset is expected.
- imem_req_valid is combinational from state and redirect_valid. All other outputs are registered.
- imem_req_addr is stable while valid && !ready. It changes only through a redirect, and the redirect cycle drops valid.
- With ready = 1 and a 1-cycle response, steady state is 3 cycles per instruction: REQ → WAIT → HOLD, consumed in HOLD.
- inst_valid rises the cycle after rsp_valid. It stays high until the inst_ready handshake or a redirect.

## Structure
- Shared include (core.v):
  - XLEN, ILEN, RESET_PC macros
  - INST_BYTES = 4
  - ifu state encoding constants (2-bit)
- Sub-module ifu_inst_buf: the one-entry valid/ready output register with a flush input. The FSM and PC logic stay in ifu.

## Test plan
- Reset and first fetch: release rst, keep ready = 1, respond 1 cycle later with 32'h00000413 → first request addr 80000000; inst_valid rises with inst_pc = 80000000, inst = 00000413.
- Sequential fetch with backpressure: inst_ready held low 5 cycles → outputs stable; no new request; after consume, next addr = 80000004.
- Memory stall: imem_req_ready low 3 cycles → req_valid and addr 80000008 held; accepted on cycle 4.
- Redirect in S_WAIT: redirect_pc = 80000103 before the response → late response discarded; next request addr 80000100; no inst_valid for the dropped word.
- Redirect coinciding with response: redirect_valid and rsp_valid in the same cycle → response dropped; next request at the redirect target.
- Fault and wrap: rsp_err = 1 → inst_fault = 1 with correct inst_pc. Redirect to FFFFFFFC and consume → next addr 00000000.
